led_scan_mux: RTL

//  Downstream display stage for topLevel. Takes the four 8-bit seven-segment patterns
//  (LED0..LED3) and time-multiplexes them onto one shared segment bus with one-hot

---
 rtl/led_scan_mux.sv | 129 ++++++++++++
 1 files changed

// File: rtl/led_scan_mux.sv
// Multiplexes four active-low seven-segment patterns onto one segment bus with blanking and
// frame-synchronous shadow reload. Optional blinking is enabled by defining SCAN_BLINK_EN.
module led_scan_mux #(
  parameter int DIV          = 50000,
  parameter int BLANK        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] LED0,
  input  logic [7:0] LED1,
  input  logic [7:0] LED2,
  input  logic [7:0] LED3,
`ifdef SCAN_BLINK_EN
  input  logic       blink,
`endif
  output logic [7:0] seg_out,
  output logic [3:0] an_out,
  output logic       frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [7:0]    shadow_q [4];
  logic [7:0]    shadow_d [4];
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          tick_q, tick_d;
  logic          last_slot, frame_end, blink_dark;

`ifdef SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;

  // Blink phase flips every BLINK_FRAMES frame ends; idle (blink=0) parks it at lit.
  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (!blink) begin
      fcnt_d  = '0;
      phase_d = 1'b0;
    end else if (frame_end) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_dark = blink & phase_q;
`else
  logic unused_cfg;
  assign unused_cfg = (BLINK_FRAMES > 0);
  assign blink_dark = 1'b0;
`endif

  assign last_slot = (div_cnt_q == CW'(DIV - 1));
  assign frame_end = en && (digit_q == 2'd3) && last_slot;

  always_comb begin
    div_cnt_d = div_cnt_q + CW'(1);
    digit_d   = digit_q;
    shadow_d  = shadow_q;
    seg_d     = 8'hFF;
    an_d      = 4'hF;
    tick_d    = frame_end;

    if (!en) begin
      div_cnt_d = '0;
      digit_d   = 2'd0;
    end else if (last_slot) begin
      div_cnt_d = '0;
      digit_d   = digit_q + 2'd1;
    end

    if (frame_end) begin
      shadow_d[0] = LED0;
      shadow_d[1] = LED1;
      shadow_d[2] = LED2;
      shadow_d[3] = LED3;
    end

    // Lit only inside the non-blank part of a slot; the blank gap hides segment switching.
    if (en && !blink_dark && !(32'(div_cnt_q) < BLANK)) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = shadow_q[digit_q];
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      div_cnt_q <= '0;
      digit_q   <= 2'd0;
      for (int i = 0; i < 4; i++) shadow_q[i] <= 8'hFF;
      seg_q     <= 8'hFF;
      an_q      <= 4'hF;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      digit_q   <= digit_d;
      shadow_q  <= shadow_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      tick_q    <= tick_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_tick = tick_q;

endmodule
